// File: rtl/cpu_run_controller.sv
// cpu_run_controller: reset/run/step/breakpoint sequencer gating a CPU clock enable
module cpu_run_controller #(
  parameter int PC_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] run_len,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic [1:0]           halt_cause
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  typedef enum logic [2:0] {HOLD, IDLE, RUN, STEP, HALT} state_t;
  state_t               state;
  logic [HW-1:0]        hold_cnt;
  logic [1:0]           mode_q;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 first;
  logic                 run_n, bp_hit, cnt_zero;
  assign run_n     = mode_q == 2'b01;
  // the first RUN cycle skips the compare so a resume steps past the breakpoint
  assign bp_hit    = mode_q == 2'b10 && !first && pc == bp_addr;
  assign cnt_zero  = run_n && remaining == '0;
  assign cpu_en    = state == STEP || (state == RUN && !stop && !bp_hit && !cnt_zero);
  assign cpu_reset = state == HOLD;
  assign busy      = state == HOLD || state == RUN || state == STEP;
  assign halted    = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      mode_q     <= 2'b00;
      remaining  <= '0;
      first      <= 1'b0;
      cycles     <= '0;
      halt_cause <= 2'b00;
    end else begin
      if (cpu_en && cycles != '1) cycles <= cycles + 1'b1;
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(RST_CYCLES - 1)) state <= IDLE;
        end
        IDLE, HALT: begin
          if (start) begin
            state      <= RUN;
            mode_q     <= mode;
            remaining  <= run_len;
            cycles     <= '0;
            halt_cause <= 2'b00;
            first      <= 1'b1;
          end else if (step) state <= STEP;
        end
        RUN: begin
          first <= 1'b0;
          if (cpu_en && run_n) remaining <= remaining - 1'b1;
          if (stop) begin
            state      <= HALT;
            halt_cause <= 2'b11;
          end else if (bp_hit) begin
            state      <= HALT;
            halt_cause <= 2'b10;
          end else if (run_n && remaining <= CNT_WIDTH'(1)) begin
            state      <= HALT;
            halt_cause <= 2'b01;
          end
        end
        STEP: state <= HALT;
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: cycle-by-cycle vector table with expected-result queue
module tb_cpu_run_controller;
  localparam int PW = 32;
  localparam int CW = 8;
  logic          clk = 0, reset = 1, start = 0, step = 0, stop = 0;
  logic [1:0]    mode = 0;
  logic [CW-1:0] run_len = 0;
  logic [PW-1:0] bp_addr = 0, pc = 0;
  logic          cpu_reset, cpu_en, busy, halted;
  logic [CW-1:0] cycles;
  logic [1:0]    halt_cause;
  cpu_run_controller #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop), .mode(mode),
    .run_len(run_len), .bp_addr(bp_addr), .pc(pc), .cpu_reset(cpu_reset), .cpu_en(cpu_en),
    .busy(busy), .halted(halted), .cycles(cycles), .halt_cause(halt_cause)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, st, sp, so;
    logic [1:0] md;
    logic [CW-1:0] len;
    logic [PW-1:0] bp, p;
    logic e_rst, e_en, e_busy, e_halt;
    logic [1:0] e_cause;
    logic [CW-1:0] e_cyc;
  } vec_t;
  typedef struct {
    logic e_rst, e_en, e_busy, e_halt;
    logic [1:0] e_cause;
    logic [CW-1:0] e_cyc;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  function automatic vec_t v(input logic r, st, sp, so, input logic [1:0] md, input int len,
                             input int bp, p, input logic er, ee, eb, eh, input logic [1:0] ec,
                             input int cy);
    vec_t x;
    x.r = r; x.st = st; x.sp = sp; x.so = so; x.md = md; x.len = CW'(len);
    x.bp = PW'(bp); x.p = PW'(p);
    x.e_rst = er; x.e_en = ee; x.e_busy = eb; x.e_halt = eh; x.e_cause = ec; x.e_cyc = CW'(cy);
    return x;
  endfunction
  task automatic apply(input vec_t x, input string name);
    exp_t e;
    @(negedge clk);
    reset = x.r; start = x.st; step = x.sp; stop = x.so; mode = x.md;
    run_len = x.len; bp_addr = x.bp; pc = x.p;
    sb.push_back('{x.e_rst, x.e_en, x.e_busy, x.e_halt, x.e_cause, x.e_cyc});
    #1;
    e = sb.pop_front();
    n_vec++;
    if ({cpu_reset, cpu_en, busy, halted, halt_cause, cycles} !==
        {e.e_rst, e.e_en, e.e_busy, e.e_halt, e.e_cause, e.e_cyc}) begin
      n_err++;
      $display("FAIL %s: got rst=%b en=%b busy=%b halted=%b cause=%b cycles=%0d, want rst=%b en=%b busy=%b halted=%b cause=%b cycles=%0d",
               name, cpu_reset, cpu_en, busy, halted, halt_cause, cycles,
               e.e_rst, e.e_en, e.e_busy, e.e_halt, e.e_cause, e.e_cyc);
    end
  endtask
  initial begin
    // cold reset then release
    tbl.push_back(v(0,0,0,0,0,0,0,0,    1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,0,0,0,0));
    // run-N of 5 with mode/run_len churn and a stray start during RUN
    tbl.push_back(v(0,1,0,0,1,5,0,0,    0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,5,0,0,    0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,99,0,0,   0,1,1,0,0,1));
    tbl.push_back(v(0,1,0,0,0,99,0,0,   0,1,1,0,0,2));
    tbl.push_back(v(0,0,0,0,1,5,0,0,    0,1,1,0,0,3));
    tbl.push_back(v(0,0,0,0,1,5,0,0,    0,1,1,0,0,4));
    tbl.push_back(v(0,0,0,0,1,5,0,0,    0,0,0,1,1,5));
    // breakpoint at 0x10, then resume past it and stop
    tbl.push_back(v(0,1,0,0,2,0,'h10,0,    0,0,0,1,1,5));
    tbl.push_back(v(0,0,0,0,2,0,'h10,0,    0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,2,0,'h10,4,    0,1,1,0,0,1));
    tbl.push_back(v(0,0,0,0,2,0,'h10,8,    0,1,1,0,0,2));
    tbl.push_back(v(0,0,0,0,2,0,'h10,'hc,  0,1,1,0,0,3));
    tbl.push_back(v(0,0,0,0,2,0,'h10,'h10, 0,0,1,0,0,4));
    tbl.push_back(v(0,1,0,0,2,0,'h10,'h10, 0,0,0,1,2,4));
    tbl.push_back(v(0,0,0,0,2,0,'h10,'h10, 0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,2,0,'h10,'h14, 0,1,1,0,0,1));
    tbl.push_back(v(0,0,0,1,2,0,'h10,'h18, 0,0,1,0,0,2));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,0,1,3,2));
    // free run, stop on 3rd cycle, then a single step
    tbl.push_back(v(0,1,0,0,0,0,0,0,    0,0,0,1,3,2));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,1,1,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,0,0,    0,1,1,0,0,1));
    tbl.push_back(v(0,0,0,1,0,0,0,0,    0,0,1,0,0,2));
    tbl.push_back(v(0,0,1,0,0,0,0,0,    0,0,0,1,3,2));
    tbl.push_back(v(0,0,1,0,0,0,0,0,    0,1,1,0,3,2));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,0,1,3,3));
    // run_len of zero
    tbl.push_back(v(0,1,0,0,1,0,0,0,    0,0,0,1,3,3));
    tbl.push_back(v(0,0,0,0,1,0,0,0,    0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,0,0,0,    0,0,0,1,1,0));
    // stop outranks a breakpoint match
    tbl.push_back(v(0,1,0,0,2,0,'h20,'h20, 0,0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,2,0,'h20,'h20, 0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,1,2,0,'h20,'h20, 0,0,1,0,0,1));
    tbl.push_back(v(0,0,0,0,2,0,'h20,'h20, 0,0,0,1,3,1));
    // start beats step
    tbl.push_back(v(0,1,1,0,1,2,0,0,    0,0,0,1,3,1));
    tbl.push_back(v(0,0,0,0,1,2,0,0,    0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,2,0,0,    0,1,1,0,0,1));
    tbl.push_back(v(0,0,0,0,1,2,0,0,    0,0,0,1,1,2));
    // reset on the 4th enabled cycle of run-N 8, then reassert in HOLD
    tbl.push_back(v(0,1,0,0,1,8,0,0,    0,0,0,1,1,2));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    0,1,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    0,1,1,0,0,1));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    0,1,1,0,0,2));
    tbl.push_back(v(1,0,0,0,1,8,0,0,    0,1,1,0,0,3));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    1,0,1,0,0,0));
    tbl.push_back(v(1,0,0,0,1,8,0,0,    1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    1,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,1,8,0,0,    0,0,0,0,0,0));
    @(posedge clk);
    #1 reset = 0;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // cycle counter saturation across a long free run and a step
    apply(v(0,1,0,0,0,0,0,0, 0,0,0,0,0,0), "sat_start");
    for (int i = 0; i < 300; i++)
      apply(v(0,0,0,0,0,0,0,0, 0,1,1,0,0,(i > 255) ? 255 : i), $sformatf("sat_run%0d", i));
    apply(v(0,0,0,1,0,0,0,0, 0,0,1,0,0,255), "sat_stop");
    apply(v(0,0,1,0,0,0,0,0, 0,0,0,1,3,255), "sat_halt");
    apply(v(0,0,0,0,0,0,0,0, 0,1,1,0,3,255), "sat_step");
    apply(v(0,0,0,0,0,0,0,0, 0,0,0,1,3,255), "sat_end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
